// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared widths, opcodes and control encodings for the ID stage
package decode_stage_pkg;

    localparam int WORD_SIZE = 32;
    localparam int REG_ADDR  = 5;
    localparam int NUM_REGS  = 32;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_control;
        logic [1:0] imm_src;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic                  alu_src;
        logic [1:0]            result_src;
        logic [2:0]            alu_control;
        logic                  illegal;
        logic [WORD_SIZE-1:0]  rd1;
        logic [WORD_SIZE-1:0]  rd2;
        logic [WORD_SIZE-1:0]  imm_ext;
        logic [REG_ADDR-1:0]   rs1;
        logic [REG_ADDR-1:0]   rs2;
        logic [REG_ADDR-1:0]   rd;
        logic [WORD_SIZE-1:0]  pc;
        logic [WORD_SIZE-1:0]  pc_plus4;
    } idex_t;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - IF/ID inputs, WB write port and ID/EX outputs of the decode stage
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic [WORD_SIZE-1:0] InstrD;
    logic [WORD_SIZE-1:0] PCD;
    logic [WORD_SIZE-1:0] PCPlus4D;
    logic                 FlushE;
    logic                 RegWriteW;
    logic [REG_ADDR-1:0]  RdW;
    logic [WORD_SIZE-1:0] ResultW;

    logic [REG_ADDR-1:0]  Rs1D;
    logic [REG_ADDR-1:0]  Rs2D;
    logic                 RegWriteE;
    logic                 MemWriteE;
    logic                 JumpE;
    logic                 BranchE;
    logic                 ALUSrcE;
    logic [1:0]           ResultSrcE;
    logic [2:0]           ALUControlE;
    logic                 IllegalE;
    logic [WORD_SIZE-1:0] RD1E;
    logic [WORD_SIZE-1:0] RD2E;
    logic [WORD_SIZE-1:0] ImmExtE;
    logic [REG_ADDR-1:0]  Rs1E;
    logic [REG_ADDR-1:0]  Rs2E;
    logic [REG_ADDR-1:0]  RdE;
    logic [WORD_SIZE-1:0] PCE;
    logic [WORD_SIZE-1:0] PCPlus4E;

    modport master (
        output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
        input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        input  ResultSrcE, ALUControlE, IllegalE, RD1E, RD2E, ImmExtE,
        input  Rs1E, Rs2E, RdE, PCE, PCPlus4E
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
        output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        output ResultSrcE, ALUControlE, IllegalE, RD1E, RD2E, ImmExtE,
        output Rs1E, Rs2E, RdE, PCE, PCPlus4E
    );

endinterface

// File: rtl/decode_stage_regfile.sv
// rtl/decode_stage_regfile.sv - 2R/1W register file with x0 hardwired zero and WB write-through
module decode_stage_regfile
    import decode_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_ADDR-1:0]  ra1,
    input  logic [REG_ADDR-1:0]  ra2,
    input  logic                 we,
    input  logic [REG_ADDR-1:0]  wa,
    input  logic [WORD_SIZE-1:0] wd,
    output logic [WORD_SIZE-1:0] rd1,
    output logic [WORD_SIZE-1:0] rd2
);

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
    logic                 wr_en;

    assign wr_en = we && (wa != '0);

    // Next register contents: only a non-x0 WB write changes state
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wa] = wd;
        end
    end

    // Register storage, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: x0 reads zero, a same-cycle WB write to the read index wins
    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wr_en && (wa == ra1)) begin
            rd1 = wd;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wr_en && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I ID stage: control decode, operand read, immediate extend, ID/EX register
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    decode_stage_if.slave bus
);

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] rf_rd1;
    logic [WORD_SIZE-1:0] rf_rd2;
    logic [WORD_SIZE-1:0] imm_ext;
    ctrl_t                ctrl;
    idex_t                idex_d;
    idex_t                idex_q;

    assign instr    = bus.InstrD;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];

    assign bus.Rs1D = instr[19:15];
    assign bus.Rs2D = instr[24:20];

    decode_stage_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (instr[19:15]),
        .ra2 (instr[24:20]),
        .we  (bus.RegWriteW),
        .wa  (bus.RdW),
        .wd  (bus.ResultW),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2)
    );

    // Main control decode; any unsupported opcode/funct collapses to an all-zero word with illegal set
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.imm_src    = IMM_I;
                ctrl.illegal    = (funct3 != 3'b010);
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
                ctrl.illegal   = (funct3 != 3'b010);
            end
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                case ({funct7b5, funct3})
                    4'b0_000: ctrl.alu_control = ALU_ADD;
                    4'b1_000: ctrl.alu_control = ALU_SUB;
                    4'b0_111: ctrl.alu_control = ALU_AND;
                    4'b0_110: ctrl.alu_control = ALU_OR;
                    4'b0_010: ctrl.alu_control = ALU_SLT;
                    default:  ctrl.illegal     = 1'b1;
                endcase
            end
            OP_IALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_I;
                case (funct3)
                    3'b000:  ctrl.alu_control = ALU_ADD;
                    3'b111:  ctrl.alu_control = ALU_AND;
                    3'b110:  ctrl.alu_control = ALU_OR;
                    3'b010:  ctrl.alu_control = ALU_SLT;
                    default: ctrl.illegal     = 1'b1;
                endcase
            end
            OP_BEQ: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
                ctrl.imm_src     = IMM_B;
                ctrl.illegal     = (funct3 != 3'b000);
            end
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_src    = IMM_J;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
        if (ctrl.illegal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

    // Immediate sign extension by format
    always_comb begin
        imm_ext = '0;
        case (ctrl.imm_src)
            IMM_I: imm_ext = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm_ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // Next ID/EX contents; a flush loads a bubble of all zeros
    always_comb begin
        idex_d             = '0;
        idex_d.reg_write   = ctrl.reg_write;
        idex_d.mem_write   = ctrl.mem_write;
        idex_d.jump        = ctrl.jump;
        idex_d.branch      = ctrl.branch;
        idex_d.alu_src     = ctrl.alu_src;
        idex_d.result_src  = ctrl.result_src;
        idex_d.alu_control = ctrl.alu_control;
        idex_d.illegal     = ctrl.illegal;
        idex_d.rd1         = rf_rd1;
        idex_d.rd2         = rf_rd2;
        idex_d.imm_ext     = imm_ext;
        idex_d.rs1         = instr[19:15];
        idex_d.rs2         = instr[24:20];
        idex_d.rd          = instr[11:7];
        idex_d.pc          = bus.PCD;
        idex_d.pc_plus4    = bus.PCPlus4D;
        if (bus.FlushE) begin
            idex_d = '0;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.RegWriteE   = idex_q.reg_write;
    assign bus.MemWriteE   = idex_q.mem_write;
    assign bus.JumpE       = idex_q.jump;
    assign bus.BranchE     = idex_q.branch;
    assign bus.ALUSrcE     = idex_q.alu_src;
    assign bus.ResultSrcE  = idex_q.result_src;
    assign bus.ALUControlE = idex_q.alu_control;
    assign bus.IllegalE    = idex_q.illegal;
    assign bus.RD1E        = idex_q.rd1;
    assign bus.RD2E        = idex_q.rd2;
    assign bus.ImmExtE     = idex_q.imm_ext;
    assign bus.Rs1E        = idex_q.rs1;
    assign bus.Rs2E        = idex_q.rs2;
    assign bus.RdE         = idex_q.rd;
    assign bus.PCE         = idex_q.pc;
    assign bus.PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic flush, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        bus.InstrD    = instr;
        bus.PCD       = pc;
        bus.PCPlus4D  = pc + 32'd4;
        bus.FlushE    = flush;
        bus.RegWriteW = we;
        bus.RdW       = wa;
        bus.ResultW   = wd;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        chk("reset_regwrite", {31'b0, bus.RegWriteE}, 32'd0);
        chk("reset_rd1",      bus.RD1E,               32'd0);
        chk("reset_pc",       bus.PCE,                32'd0);
        chk("reset_illegal",  {31'b0, bus.IllegalE},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // addi x1,x0,5 while WB writes x1=0x55
        drive(32'h00500093, 32'h100, 1'b0, 1'b1, 5'd1, 32'h55);
        #1;
        chk("addi_rs1d", {27'b0, bus.Rs1D}, 32'd0);
        chk("addi_rs2d", {27'b0, bus.Rs2D}, 32'd5);
        step();
        chk("addi_regwrite", {31'b0, bus.RegWriteE},  32'd1);
        chk("addi_alusrc",   {31'b0, bus.ALUSrcE},    32'd1);
        chk("addi_aluctl",   {29'b0, bus.ALUControlE}, 32'd0);
        chk("addi_resultsrc",{30'b0, bus.ResultSrcE}, 32'd0);
        chk("addi_imm",      bus.ImmExtE,             32'd5);
        chk("addi_rd",       {27'b0, bus.RdE},        32'd1);
        chk("addi_rd1",      bus.RD1E,                32'd0);
        chk("addi_pc",       bus.PCE,                 32'h100);
        chk("addi_pc4",      bus.PCPlus4E,            32'h104);

        // add x4,x3,x0 with a same-cycle WB write of x3
        drive(32'h00018233, 32'h104, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
        step();
        chk("byp_rd1",      bus.RD1E,               32'hDEADBEEF);
        chk("byp_rd2",      bus.RD2E,               32'd0);
        chk("byp_rd",       {27'b0, bus.RdE},       32'd4);
        chk("byp_rs1e",     {27'b0, bus.Rs1E},      32'd3);
        chk("byp_alusrc",   {31'b0, bus.ALUSrcE},   32'd0);

        // x3 now holds the written value from storage
        drive(32'h00018233, 32'h108, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("x3_stored", bus.RD1E, 32'hDEADBEEF);

        // write to x0 is neither bypassed nor stored
        drive(32'h00000233, 32'h10C, 1'b0, 1'b1, 5'd0, 32'h12345678);
        step();
        chk("x0_bypass", bus.RD1E, 32'd0);
        drive(32'h00000233, 32'h110, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("x0_stored_rd1", bus.RD1E, 32'd0);
        chk("x0_stored_rd2", bus.RD2E, 32'd0);

        // beq x0,x0,-4
        drive(32'hFE000EE3, 32'h114, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("beq_branch",   {31'b0, bus.BranchE},     32'd1);
        chk("beq_aluctl",   {29'b0, bus.ALUControlE}, 32'd1);
        chk("beq_imm",      bus.ImmExtE,              32'hFFFFFFFC);
        chk("beq_regwrite", {31'b0, bus.RegWriteE},   32'd0);

        // sub x1,x2,x3
        drive(32'h403100B3, 32'h118, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("sub_aluctl", {29'b0, bus.ALUControlE}, 32'd1);
        chk("sub_rd2",    bus.RD2E,                 32'hDEADBEEF);

        // jal x0,8
        drive(32'h0080006F, 32'h11C, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("jal_jump",      {31'b0, bus.JumpE},      32'd1);
        chk("jal_regwrite",  {31'b0, bus.RegWriteE},  32'd1);
        chk("jal_resultsrc", {30'b0, bus.ResultSrcE}, 32'd2);
        chk("jal_imm",       bus.ImmExtE,             32'd8);

        // sw x2,8(x1) with x1 bypassed from WB
        drive(32'h0020A423, 32'h120, 1'b0, 1'b1, 5'd1, 32'h1000);
        step();
        chk("sw_memwrite", {31'b0, bus.MemWriteE}, 32'd1);
        chk("sw_imm",      bus.ImmExtE,            32'd8);
        chk("sw_rs2e",     {27'b0, bus.Rs2E},      32'd2);
        chk("sw_regwrite", {31'b0, bus.RegWriteE}, 32'd0);
        chk("sw_alusrc",   {31'b0, bus.ALUSrcE},   32'd1);
        chk("sw_rd1",      bus.RD1E,               32'h1000);

        // same sw flushed; WB write of x5 must still land
        drive(32'h0020A423, 32'h120, 1'b1, 1'b1, 5'd5, 32'hA5A5A5A5);
        step();
        chk("flush_memwrite", {31'b0, bus.MemWriteE}, 32'd0);
        chk("flush_imm",      bus.ImmExtE,            32'd0);
        chk("flush_rs2e",     {27'b0, bus.Rs2E},      32'd0);
        chk("flush_rd1",      bus.RD1E,               32'd0);
        chk("flush_pc",       bus.PCE,                32'd0);
        chk("flush_alusrc",   {31'b0, bus.ALUSrcE},   32'd0);

        // add x6,x5,x0 reads the value written during the flush
        drive(32'h00028333, 32'h124, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("flush_wb_kept", bus.RD1E, 32'hA5A5A5A5);

        // illegal opcode
        drive(32'h0000007F, 32'h128, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("ill_flag",     {31'b0, bus.IllegalE},    32'd1);
        chk("ill_regwrite", {31'b0, bus.RegWriteE},   32'd0);
        chk("ill_alusrc",   {31'b0, bus.ALUSrcE},     32'd0);
        chk("ill_aluctl",   {29'b0, bus.ALUControlE}, 32'd0);
        chk("ill_pc",       bus.PCE,                  32'h128);

        // next legal instruction clears the flag
        drive(32'h00500093, 32'h12C, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("legal_after_ill", {31'b0, bus.IllegalE},  32'd0);
        chk("legal_regwrite",  {31'b0, bus.RegWriteE}, 32'd1);

        // asynchronous reset mid-run clears E outputs without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_regwrite", {31'b0, bus.RegWriteE}, 32'd0);
        chk("async_rst_imm",      bus.ImmExtE,            32'd0);
        chk("async_rst_pc",       bus.PCE,                32'd0);
        @(negedge clk);
        rst = 1'b0;

        // addi x1,x1,0: x1 was cleared by reset
        drive(32'h00008093, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("post_rst_x1",       bus.RD1E,               32'd0);
        chk("post_rst_regwrite", {31'b0, bus.RegWriteE}, 32'd1);
        chk("post_rst_pc",       bus.PCE,                32'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Consumes InstrD/PCD/PCPlus4D and decodes the control word.
- Reads the register file, which is written from WB, and sign-extends immediates.
- Registers everything into the ID/EX pipeline register; FlushE bubble support serves the hazard unit.

Parameters:
WORD_SIZE, 32, datapath/instruction width
REG_ADDR, 5, register index width
NUM_REGS, 32, architectural registers (x0 hardwired zero)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
InstrD  input  WORD_SIZE  instruction from IF/ID
PCD  input  WORD_SIZE  PC of InstrD
PCPlus4D  input  WORD_SIZE  PCD+4
FlushE  input  1  load bubble into ID/EX this edge
RegWriteW  input  1  WB write enable
RdW  input  REG_ADDR  WB destination
ResultW  input  WORD_SIZE  WB data
Rs1D  output  REG_ADDR  InstrD[19:15], combinational, for hazard unit
Rs2D  output  REG_ADDR  InstrD[24:20], combinational
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1 each  registered control
ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4
ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
IllegalE  output  1  unsupported opcode/funct in E
RD1E, RD2E  output  WORD_SIZE  register operands
ImmExtE  output  WORD_SIZE  sign-extended immediate
Rs1E, Rs2E, RdE  output  REG_ADDR  register indices
PCE, PCPlus4E  output  WORD_SIZE  forwarded PCs

Behaviour:
- Reset: rst=1 asynchronously clears every ID/EX output to 0 and every register-file entry to 0. Mid-operation reset discards the in-flight instruction; the first valid E-stage contents appear one edge after rst falls.
- Latency: one cycle. InstrD present before edge N appears on the *E outputs after edge N.
- Supported opcodes:
  - lw 0000011: RegWrite=1, ALUSrc=1, ResultSrc=01, ImmSrc=I, ALU add.
  - sw 0100011: MemWrite=1, ALUSrc=1, ImmSrc=S, ALU add.
  - R-type 0110011, ALU by funct3/funct7[5]: add, sub, and, or, slt.
  - I-ALU 0010011: addi, andi, ori, slti; funct7 ignored.
  - beq 1100011: Branch=1, ALU sub, ImmSrc=B.
  - jal 1101111: Jump=1, RegWrite=1, ResultSrc=10, ImmSrc=J.
- Illegal decode: any other opcode or funct combination loads all control bits 0 and sets IllegalE=1. Data fields still load.
- Immediates:
  - I = {20{i[31]}, i[31:20]}
  - S = {20{i[31]}, i[31:25], i[11:7]}
  - B = {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
  - J = {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
- Register file: written on posedge clk when RegWriteW=1 and RdW≠0. Writes to x0 are discarded; reads of x0 return 0.
- Write-through bypass: if RegWriteW=1, RdW≠0 and RdW matches rs1/rs2, RD1/RD2 take ResultW in the same cycle.
- FlushE=1 at an edge:
  - RegWriteE, MemWriteE, JumpE, BranchE and IllegalE load 0.
  - All other E fields also load 0.
  - The register-file write in the same cycle still happens.
- ID/EX has no stall input; the hazard unit stalls upstream and flushes E.

Decomposition:
- Shared constants file gets: opcode localparams, ALUControl encodings, ResultSrc and ImmSrc (00 I, 01 S, 10 B, 11 J) encodings, WORD_SIZE, and the new REG_ADDR.
- One natural sub-module: registerFile, with the 2-read/1-write ports, x0 rule, bypass and async reset.
- Control decode and immediate extension stay in decode_stage.

Test Plan:
- Reset: assert rst mid-run -> all E outputs 0 immediately; after release, reading x1 -> 0.
- addi: InstrD=0x00500093 (addi x1,x0,5) -> next edge RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, RdE=1, RD1E=0.
- Bypass: RegWriteW=1, RdW=3, ResultW=0xDEADBEEF with InstrD=0x00018233 (add x4,x3,x0) in the same cycle -> RD1E=0xDEADBEEF, RdE=4. Same with RdW=0 -> RD1E unchanged, x0 stays 0.
- beq: InstrD=0xFE000EE3 (beq x0,x0,-4) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC, RegWriteE=0.
- sw then flush: InstrD=0x0020A423 (sw x2,8(x1)) -> MemWriteE=1, ImmExtE=8, Rs2E=2. Same instruction with FlushE=1 -> MemWriteE=0, all E fields 0.
- Illegal: InstrD=0x0000007F -> IllegalE=1, all control 0. Next legal instruction -> IllegalE=0.
